key_sched_ctrl: RTL and testbench

KEY_SCHED_CTRL -- requirements
Module: key_sched_ctrl

---
 rtl/key_sched_ctrl_if.sv | 18 +
 rtl/key_sched_ctrl.sv | 84 ++++++++
 tb/tb_key_sched_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/key_sched_ctrl_if.sv
// key_sched_if: key load, status and round-key read bundle for key_sched_ctrl.
interface key_sched_if;
  logic [0:255] key_i;
  logic         key_valid_i;
  logic         key_ready_o;
  logic         busy_o;
  logic         keys_valid_o;
  logic [0:3]   rk_idx_i;
  logic [0:127] rk_o;
  modport master (
    output key_i, key_valid_i, rk_idx_i,
    input  key_ready_o, busy_o, keys_valid_o, rk_o
  );
  modport slave (
    input  key_i, key_valid_i, rk_idx_i,
    output key_ready_o, busy_o, keys_valid_o, rk_o
  );
endinterface

// File: rtl/key_sched_ctrl.sv
// key_sched_ctrl: AES-256 key expansion into 15 stored round keys, one 8-word step per cycle.
module round_key (
  input  logic [0:255] k,
  input  logic [0:4]   r,
  output logic [0:255] result
);
  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  function automatic logic [0:31] sub_word(input logic [0:31] w);
    logic [0:31] s;
    for (int i = 0; i < 4; i++) s[8*i +: 8] = SBOX[{w[8*i +: 8], 3'b000} +: 8];
    return s;
  endfunction
  function automatic logic [0:255] expand(input logic [0:255] kk, input logic [0:4] rr);
    logic [0:31] n [0:7];
    logic [7:0]  rc;
    logic [0:255] o;
    rc = 8'(8'h01 << (rr - 5'd1));
    n[0] = kk[0:31] ^ sub_word({kk[232:255], kk[224:231]}) ^ {rc, 24'h0};
    for (int i = 1; i < 8; i++)
      n[i] = kk[32*i +: 32] ^ (i == 4 ? sub_word(n[3]) : n[i-1]);
    for (int i = 0; i < 8; i++) o[32*i +: 32] = n[i];
    return o;
  endfunction
  assign result = expand(k, r);
endmodule

module key_sched_ctrl (
  input logic        clk,
  input logic        rst_n,
  key_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;
  state_t       state, state_nxt;
  logic [0:255] cur_q, result;
  logic [0:4]   r_q;
  logic [0:127] rk [0:14];
  logic         acc, last;
  round_key u_round_key (.k(cur_q), .r(r_q), .result(result));
  always_comb begin
    bus.key_ready_o = state != EXPAND;
    bus.busy_o = state == EXPAND;
    acc = bus.key_valid_i && bus.key_ready_o;
    last = bus.busy_o && r_q == 5'd7;
    state_nxt = acc ? EXPAND : last ? DONE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // Read port samples rk before this edge's write, so no same-edge bypass exists.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cur_q <= '0;
      r_q <= 5'd1;
      bus.keys_valid_o <= 1'b0;
      bus.rk_o <= '0;
      for (int i = 0; i < 15; i++) rk[i] <= '0;
    end else begin
      bus.rk_o <= &bus.rk_idx_i ? '0 : rk[bus.rk_idx_i];
      if (acc) begin
        cur_q <= bus.key_i;
        rk[0] <= bus.key_i[0:127];
        rk[1] <= bus.key_i[128:255];
        r_q <= 5'd1;
        bus.keys_valid_o <= 1'b0;
      end else if (bus.busy_o) begin
        rk[{r_q[2:4], 1'b0}] <= result[0:127];
        if (!last) rk[{r_q[2:4], 1'b1}] <= result[128:255];
        cur_q <= result;
        r_q <= last ? 5'd1 : r_q + 5'd1;
        bus.keys_valid_o <= last;
      end
    end
  assert property (@(posedge clk) disable iff (!rst_n) bus.busy_o |-> r_q inside {[5'd1:5'd7]});
  assert property (@(posedge clk) disable iff (!rst_n) bus.keys_valid_o |-> !bus.busy_o);
endmodule

// File: tb/tb_key_sched_ctrl.sv
// tb_key_sched_ctrl: directed FIPS-197 A.3, handshake, re-key, reset and random-key checks.
module tb_key_sched_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  key_sched_if bus();
  key_sched_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;

  localparam logic [0:255] KEY_A3 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [0:127] RK2_A3 = 128'h9ba354118e6925afa51a8b5f2067fcde;
  localparam logic [0:127] RK14_A3 = 128'hfe4890d1e6188d0b046df344706c631e;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] sbox [256];
  logic [0:127] exp_rk [15];

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b >>= 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic void build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endfunction

  function automatic logic [31:0] sub_w(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  function automatic void set_model(input logic [0:255] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0] rc = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = key[32*i +: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t = sub_w({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = rc << 1;
      end else if (i % 8 == 4) t = sub_w(t);
      w[i] = w[i-8] ^ t;
    end
    for (int j = 0; j < 15; j++) exp_rk[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
  endfunction

  task automatic read_all(input string tag);
    for (int i = 0; i < 15; i++) begin
      bus.rk_idx_i = 4'(i);
      @(negedge clk);
      check($sformatf("%s_rk%0d", tag, i), bus.rk_o, exp_rk[i]);
    end
  endtask

  // Loads a key with key_valid_i held through the whole expansion, watching index 14.
  task automatic run_key(input logic [0:255] key, input string tag);
    logic [0:127] old14;
    int busy_n = 0;
    int rdy_lo = 0;
    old14 = exp_rk[14];
    set_model(key);
    check({tag, "_ready"}, bus.key_ready_o, 1);
    bus.key_i = key;
    bus.key_valid_i = 1'b1;
    bus.rk_idx_i = 4'd14;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      busy_n += int'(bus.busy_o);
      rdy_lo += int'(!bus.key_ready_o);
      if (c == 1) check({tag, "_kv_drop"}, bus.keys_valid_o, 0);
      if (c == 7) check({tag, "_kv_early"}, bus.keys_valid_o, 0);
      if (c == 8) begin
        check({tag, "_kv_rise"}, bus.keys_valid_o, 1);
        check({tag, "_rk14_old"}, bus.rk_o, old14);
        bus.key_valid_i = 1'b0;
      end
      if (c == 9) check({tag, "_rk14_new"}, bus.rk_o, exp_rk[14]);
    end
    check({tag, "_busy_cycles"}, busy_n, 7);
    check({tag, "_ready_low"}, rdy_lo, 7);
  endtask

  initial begin
    bus.key_i = '0;
    bus.key_valid_i = 1'b0;
    bus.rk_idx_i = 4'd0;
    build_sbox();
    for (int j = 0; j < 15; j++) exp_rk[j] = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy_o, 0);
    check("rst_kv", bus.keys_valid_o, 0);
    check("rst_rk", bus.rk_o, 0);
    check("rst_ready", bus.key_ready_o, 1);
    rst_n = 1'b1;
    @(negedge clk);
    run_key(KEY_A3, "a3");
    read_all("a3");
    check("a3_rk0_const", exp_rk[0], KEY_A3[0:127]);
    bus.rk_idx_i = 4'd0;
    @(negedge clk);
    check("a3_rk0_half", bus.rk_o, KEY_A3[0:127]);
    bus.rk_idx_i = 4'd1;
    @(negedge clk);
    check("a3_rk1_half", bus.rk_o, KEY_A3[128:255]);
    bus.rk_idx_i = 4'd2;
    @(negedge clk);
    check("a3_rk2_fips", bus.rk_o, RK2_A3);
    bus.rk_idx_i = 4'd15;
    @(negedge clk);
    check("idx15_zero", bus.rk_o, 0);
    bus.rk_idx_i = 4'd14;
    @(negedge clk);
    check("a3_rk14_fips", bus.rk_o, RK14_A3);
    run_key({32{8'h64}}, "k64");
    read_all("k64");
    run_key(KEY_A3, "rekey");
    read_all("rekey");
    bus.rk_idx_i = 4'd14;
    @(negedge clk);
    check("rekey_rk14_fips", bus.rk_o, RK14_A3);
    bus.rk_idx_i = 4'd0;
    bus.key_i = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    bus.key_valid_i = 1'b1;
    @(negedge clk);
    bus.key_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy_pre", bus.busy_o, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", bus.busy_o, 0);
    check("mid_rst_kv", bus.keys_valid_o, 0);
    check("mid_rst_rk", bus.rk_o, 0);
    check("mid_rst_ready", bus.key_ready_o, 1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 15; j++) exp_rk[j] = '0;
    read_all("mid_rst");
    check("mid_rst_kv_hold", bus.keys_valid_o, 0);
    for (int n = 0; n < 100; n++) begin
      run_key({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
              $sformatf("rnd%0d", n));
      read_all($sformatf("rnd%0d", n));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
